// File: rtl/cortexm0_wic_pkg.sv
// ---------------------------------------------------------------------------
// cortexm0_wic_pkg
//   Shared types and constants for the Cortex-M0 wake-up interrupt controller.
//   - wic_hs_state_t : PMU/core enable-handshake state encoding. The encoding
//                      is visible on WICSTATE, so the values are fixed.
//   - WIC_MAX_LINES  : largest supported number of interrupt lines.
//   - WIC_HOLD_W     : width of the WAKEUP minimum-hold counter.
// ---------------------------------------------------------------------------
package cortexm0_wic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2,
        REL  = 2'd3
    } wic_hs_state_t;

    localparam int WIC_MAX_LINES = 64;
    localparam int WIC_HOLD_W    = 4;

endpackage : cortexm0_wic_pkg

// File: rtl/cortexm0_wic_hs.sv
// ---------------------------------------------------------------------------
// cortexm0_wic_hs
//   Four-phase enable handshake between the PMU and the core.
//   IDLE -> REQ -> ACKD -> REL -> IDLE, one state per transition. A request
//   that is withdrawn before the core acknowledges aborts from REQ to IDLE.
//   All outputs are decoded straight from the state register.
//
//   Parameters
//     ENABLE     : 0 holds the FSM in IDLE (WIC absent).
//   Ports
//     FCLK       in   clock
//     RESET      in   synchronous active-high reset
//     WICENREQ   in   enable request from the PMU
//     WICDSACKn  in   enable acknowledge from the core, active-low
//     WICDSREQn  out  enable request to the core, active-low
//     WICENACK   out  enable acknowledge to the PMU
//     WICSTATE   out  current state, for debug
// ---------------------------------------------------------------------------
module cortexm0_wic_hs
    import cortexm0_wic_pkg::*;
#(
    parameter int ENABLE = 1
) (
    input  logic       FCLK,
    input  logic       RESET,
    input  logic       WICENREQ,
    input  logic       WICDSACKn,
    output logic       WICDSREQn,
    output logic       WICENACK,
    output logic [1:0] WICSTATE
);

    wic_hs_state_t state_q;
    wic_hs_state_t state_d;
    wic_hs_state_t state_nxt;

    always_ff @(posedge FCLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each state checks only its own exit condition, so the FSM always walks
    // through every state even when a later condition is already satisfied.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (WICENREQ) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!WICDSACKn) begin
                    state_nxt = ACKD;
                end else if (!WICENREQ) begin
                    state_nxt = IDLE;
                end
            end
            ACKD: begin
                if (!WICENREQ) begin
                    state_nxt = REL;
                end
            end
            REL: begin
                if (WICDSACKn) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        state_d = (ENABLE != 0) ? state_nxt : IDLE;
    end

    // Request to the core is active (low) in REQ and ACKD; the PMU sees the
    // acknowledge from ACKD until the core releases its ack in REL.
    assign WICDSREQn = (state_q == IDLE) || (state_q == REL);
    assign WICENACK  = (state_q == ACKD) || (state_q == REL);
    assign WICSTATE  = state_q;

endmodule : cortexm0_wic_hs

// File: rtl/cortexm0_wic_gen.sv
// ---------------------------------------------------------------------------
// cortexm0_wic_gen
//   Wake-up interrupt controller for Cortex-M0 deep sleep. The core loads a
//   sensitivity mask; while armed, requested lines are pended (sticky until
//   WICCLEAR) and any pended line that is also masked in raises WAKEUP to
//   the PMU. WAKEUP is registered and, once raised, stays high for at least
//   WAKE_HOLD cycles.
//
//   Optional feature macro: CORTEXM0_WIC_EDGE_EN
//     Defined   : WICEDGE port present; lines with edge-select set pend only
//                 on a rising edge of WICINT.
//     Undefined : all lines are level sensitive, no WICEDGE port.
//
//   Parameters
//     WIC        : non-zero when the WIC is present; 0 ties all outputs off.
//     WICLINES   : number of interrupt lines, 1..64.
//     WAKE_HOLD  : minimum WAKEUP high time in FCLK cycles, 1..15.
//   Ports
//     FCLK       in   free-running clock
//     RESET      in   synchronous active-high reset
//     WICLOAD    in   load mask (and edge select) from core, arm pending
//     WICCLEAR   in   clear mask, edge select and pend, disarm
//     WICINT     in   interrupt requests from the system
//     WICMASK    in   sensitivity mask from the core
//     WICEDGE    in   per-line rising-edge select (edge build only)
//     WICENREQ   in   WIC enable request from the PMU
//     WICDSACKn  in   WIC enable acknowledge from the core, active-low
//     WAKEUP     out  registered wake-up request to the PMU
//     WICSENSE   out  current mask
//     WICPEND    out  pended lines
//     WICDSREQn  out  WIC enable request to the core, active-low
//     WICENACK   out  WIC enable acknowledge to the PMU
//     WICSTATE   out  handshake state, for debug
// ---------------------------------------------------------------------------
module cortexm0_wic_gen
    import cortexm0_wic_pkg::*;
#(
    parameter int WIC       = 1,
    parameter int WICLINES  = 8,
    parameter int WAKE_HOLD = 2
) (
    input  logic                FCLK,
    input  logic                RESET,
    input  logic                WICLOAD,
    input  logic                WICCLEAR,
    input  logic [WICLINES-1:0] WICINT,
    input  logic [WICLINES-1:0] WICMASK,
`ifdef CORTEXM0_WIC_EDGE_EN
    input  logic [WICLINES-1:0] WICEDGE,
`endif
    input  logic                WICENREQ,
    input  logic                WICDSACKn,
    output logic                WAKEUP,
    output logic [WICLINES-1:0] WICSENSE,
    output logic [WICLINES-1:0] WICPEND,
    output logic                WICDSREQn,
    output logic                WICENACK,
    output logic [1:0]          WICSTATE
);

    localparam bit WIC_EN = (WIC != 0);
    localparam logic [WIC_HOLD_W-1:0] HOLD_INIT = WIC_HOLD_W'(WAKE_HOLD - 1);

    // -----------------------------------------------------------------------
    // Enable handshake
    // -----------------------------------------------------------------------
    cortexm0_wic_hs #(
        .ENABLE (WIC)
    ) u_hs (
        .FCLK      (FCLK),
        .RESET     (RESET),
        .WICENREQ  (WICENREQ),
        .WICDSACKn (WICDSACKn),
        .WICDSREQn (WICDSREQn),
        .WICENACK  (WICENACK),
        .WICSTATE  (WICSTATE)
    );

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WICLINES-1:0]   mask_q,  mask_d;
    logic [WICLINES-1:0]   pend_q,  pend_d;
    logic                  armed_q, armed_d;
    logic                  wake_q,  wake_d;
    logic [WIC_HOLD_W-1:0] hold_q,  hold_d;

    logic [WICLINES-1:0]   hit;
    logic                  pend_en;
    logic                  wake_raw;

`ifdef CORTEXM0_WIC_EDGE_EN
    logic [WICLINES-1:0]   edge_q,    edge_d;
    logic [WICLINES-1:0]   int_dly_q, int_dly_d;
    logic [WICLINES-1:0]   edge_sel;

    // On the load cycle the edge-select register still holds the old value,
    // yet pending is already enabled; use the incoming selection so a line
    // already high at arm time is treated as the new setting dictates.
    assign edge_sel = WICLOAD ? WICEDGE : edge_q;
`endif

    // -----------------------------------------------------------------------
    // Per-line hit detection
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WICLINES; gi++) begin : g_hit
`ifdef CORTEXM0_WIC_EDGE_EN
            // Edge lines suppress the hit while the previous sample was high.
            assign hit[gi] = WICINT[gi] & ~(edge_sel[gi] & int_dly_q[gi]);
`else
            assign hit[gi] = WICINT[gi];
`endif
        end
    endgenerate

    assign pend_en  = armed_q | WICLOAD;
    // Pend is independent of the mask; the mask only qualifies wake-up.
    assign wake_raw = |(pend_q & mask_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        mask_d  = mask_q;
        pend_d  = pend_q;
        armed_d = armed_q;
        wake_d  = wake_q;
        hold_d  = hold_q;
`ifdef CORTEXM0_WIC_EDGE_EN
        edge_d    = edge_q;
        int_dly_d = WICINT;
`endif

        // CLEAR has priority over LOAD; a request arriving with CLEAR is lost.
        if (WICCLEAR) begin
            mask_d  = '0;
            pend_d  = '0;
            armed_d = 1'b0;
`ifdef CORTEXM0_WIC_EDGE_EN
            edge_d  = '0;
`endif
        end else begin
            if (WICLOAD) begin
                mask_d  = WICMASK;
                armed_d = 1'b1;
`ifdef CORTEXM0_WIC_EDGE_EN
                edge_d  = WICEDGE;
`endif
            end
            if (pend_en) begin
                pend_d = pend_q | hit;
            end
        end

        // WAKEUP rises one cycle after wake_raw and then stays up until both
        // the minimum-hold count has run out and no masked pend remains.
        if (!wake_q) begin
            if (wake_raw) begin
                wake_d = 1'b1;
                hold_d = HOLD_INIT;
            end
        end else begin
            if (hold_q != '0) begin
                hold_d = hold_q - WIC_HOLD_W'(1);
            end else if (!wake_raw) begin
                wake_d = 1'b0;
            end
        end

        // Without a WIC every register stays at its reset value.
        if (!WIC_EN) begin
            mask_d  = '0;
            pend_d  = '0;
            armed_d = 1'b0;
            wake_d  = 1'b0;
            hold_d  = '0;
`ifdef CORTEXM0_WIC_EDGE_EN
            edge_d    = '0;
            int_dly_d = '0;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge FCLK) begin
        if (RESET) begin
            mask_q  <= '0;
            pend_q  <= '0;
            armed_q <= 1'b0;
            wake_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
            wake_q  <= wake_d;
            hold_q  <= hold_d;
        end
    end

`ifdef CORTEXM0_WIC_EDGE_EN
    always_ff @(posedge FCLK) begin
        if (RESET) begin
            edge_q    <= '0;
            int_dly_q <= '0;
        end else begin
            edge_q    <= edge_d;
            int_dly_q <= int_dly_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign WAKEUP   = wake_q;
    assign WICSENSE = mask_q;
    assign WICPEND  = pend_q;

endmodule : cortexm0_wic_gen

// File: tb/tb_cortexm0_wic_gen.sv
// ---------------------------------------------------------------------------
// tb_cortexm0_wic_gen
//   Directed bench for cortexm0_wic_gen. The stimulus process drives inputs,
//   lets one FCLK edge pass and pushes the expected post-edge outputs into a
//   scoreboard queue; the monitor process samples the DUT on the falling
//   edge, pops one entry per cycle and compares the fields it selects.
//   Edge-sensitivity vectors run only when CORTEXM0_WIC_EDGE_EN is defined.
// ---------------------------------------------------------------------------
module tb_cortexm0_wic_gen;

`ifdef CORTEXM0_WIC_EDGE_EN
    localparam int L = 64;
`else
    localparam int L = 8;
`endif

    // Field-select bits for a scoreboard entry
    localparam logic [5:0] C_W   = 6'b000001;
    localparam logic [5:0] C_P   = 6'b000010;
    localparam logic [5:0] C_S   = 6'b000100;
    localparam logic [5:0] C_DQ  = 6'b001000;
    localparam logic [5:0] C_EA  = 6'b010000;
    localparam logic [5:0] C_ST  = 6'b100000;
    localparam logic [5:0] C_HS  = C_DQ | C_EA | C_ST;
    localparam logic [5:0] C_WIC = C_W | C_P | C_S;
    localparam logic [5:0] C_ALL = C_HS | C_WIC;

    typedef struct {
        string        tag;
        logic [5:0]   chk;
        logic         wake;
        logic [L-1:0] pend;
        logic [L-1:0] sense;
        logic         dsreqn;
        logic         enack;
        logic [1:0]   st;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         wicload, wicclear, wicenreq, wicdsackn;
    logic [L-1:0] wicint, wicmask;
`ifdef CORTEXM0_WIC_EDGE_EN
    logic [L-1:0] wicedge;
`endif
    logic         wakeup, wicdsreqn, wicenack;
    logic [L-1:0] wicsense, wicpend;
    logic [1:0]   wicstate;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    cortexm0_wic_gen #(
        .WIC       (1),
        .WICLINES  (L),
        .WAKE_HOLD (2)
    ) dut (
        .FCLK      (clk),
        .RESET     (rst),
        .WICLOAD   (wicload),
        .WICCLEAR  (wicclear),
        .WICINT    (wicint),
        .WICMASK   (wicmask),
`ifdef CORTEXM0_WIC_EDGE_EN
        .WICEDGE   (wicedge),
`endif
        .WICENREQ  (wicenreq),
        .WICDSACKn (wicdsackn),
        .WAKEUP    (wakeup),
        .WICSENSE  (wicsense),
        .WICPEND   (wicpend),
        .WICDSREQn (wicdsreqn),
        .WICENACK  (wicenack),
        .WICSTATE  (wicstate)
    );

    // One FCLK edge with the inputs currently applied; queue what must be
    // seen afterwards.
    task automatic cyc(input string tag, input logic [5:0] chk, input logic w,
                       input logic [L-1:0] p, input logic [L-1:0] s,
                       input logic dq, input logic ea, input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        e.tag = tag; e.chk = chk; e.wake = w; e.pend = p; e.sense = s;
        e.dsreqn = dq; e.enack = ea; e.st = st;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string f,
                       input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s %s: actual=%0h required=%0h", tag, f, act, want);
        end
    endtask

    // Monitor / checker
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                $display("txn %-14s wake=%b pend=%h sense=%h dsreqn=%b enack=%b state=%0d",
                         cur.tag, wakeup, wicpend, wicsense, wicdsreqn, wicenack, wicstate);
                if (cur.chk[0]) cmp(cur.tag, "WAKEUP",    64'(wakeup),    64'(cur.wake));
                if (cur.chk[1]) cmp(cur.tag, "WICPEND",   64'(wicpend),   64'(cur.pend));
                if (cur.chk[2]) cmp(cur.tag, "WICSENSE",  64'(wicsense),  64'(cur.sense));
                if (cur.chk[3]) cmp(cur.tag, "WICDSREQn", 64'(wicdsreqn), 64'(cur.dsreqn));
                if (cur.chk[4]) cmp(cur.tag, "WICENACK",  64'(wicenack),  64'(cur.enack));
                if (cur.chk[5]) cmp(cur.tag, "WICSTATE",  64'(wicstate),  64'(cur.st));
            end else if (stim_done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    // Stimulus
    initial begin : stimulus
        rst = 1'b1; wicload = 1'b0; wicclear = 1'b0; wicenreq = 1'b0; wicdsackn = 1'b1;
        wicint = '0; wicmask = '0;
`ifdef CORTEXM0_WIC_EDGE_EN
        wicedge = '0;
`endif
        cyc("reset0", C_ALL, 0, '0, '0, 1, 0, 0);
        // Drive lines during reset: nothing may be captured.
        wicload = 1'b1; wicmask = '1; wicint = '1; wicenreq = 1'b1;
        cyc("reset1", C_ALL, 0, '0, '0, 1, 0, 0);
        rst = 1'b0; wicload = 1'b0; wicmask = '0; wicint = '0; wicenreq = 1'b0;
        cyc("idle", C_ALL, 0, '0, '0, 1, 0, 0);

        // Full handshake 0,1,2,3,0
        wicenreq = 1'b1;
        cyc("hs_req", C_HS, 0, '0, '0, 0, 0, 1);
        wicdsackn = 1'b0;
        cyc("hs_ackd", C_HS, 0, '0, '0, 0, 1, 2);
        wicenreq = 1'b0;
        cyc("hs_rel", C_HS, 0, '0, '0, 1, 1, 3);
        wicdsackn = 1'b1;
        cyc("hs_idle", C_HS, 0, '0, '0, 1, 0, 0);

        // Abort: request withdrawn before ack
        wicenreq = 1'b1;
        cyc("ab_req", C_HS, 0, '0, '0, 0, 0, 1);
        wicenreq = 1'b0;
        cyc("ab_idle", C_HS, 0, '0, '0, 1, 0, 0);
        cyc("ab_stay", C_HS, 0, '0, '0, 1, 0, 0);

        // No state skipping even when exit conditions are already true
        wicenreq = 1'b1; wicdsackn = 1'b0;
        cyc("ns_req", C_HS, 0, '0, '0, 0, 0, 1);
        cyc("ns_ackd", C_HS, 0, '0, '0, 0, 1, 2);
        wicenreq = 1'b0; wicdsackn = 1'b1;
        cyc("ns_rel", C_HS, 0, '0, '0, 1, 1, 3);
        cyc("ns_idle", C_HS, 0, '0, '0, 1, 0, 0);

        // Reset in the middle of a handshake
        wicenreq = 1'b1;
        cyc("mr_req", C_HS, 0, '0, '0, 0, 0, 1);
        wicdsackn = 1'b0;
        cyc("mr_ackd", C_HS, 0, '0, '0, 0, 1, 2);
        rst = 1'b1;
        cyc("mr_reset", C_HS, 0, '0, '0, 1, 0, 0);
        rst = 1'b0; wicenreq = 1'b0; wicdsackn = 1'b1;
        cyc("mr_idle", C_HS, 0, '0, '0, 1, 0, 0);

        // Level wake with minimum hold across a clear
        wicload = 1'b1; wicmask = L'(8'h05);
        cyc("lv_load", C_WIC, 0, '0, L'(8'h05), 1, 0, 0);
        wicload = 1'b0; wicmask = '0; wicint = L'(8'h04);
        cyc("lv_pend", C_WIC, 0, L'(8'h04), L'(8'h05), 1, 0, 0);
        wicint = '0;
        cyc("lv_wake", C_WIC, 1, L'(8'h04), L'(8'h05), 1, 0, 0);
        wicclear = 1'b1;
        cyc("lv_hold", C_WIC, 1, '0, '0, 1, 0, 0);
        wicclear = 1'b0;
        cyc("lv_fall", C_WIC, 0, '0, '0, 1, 0, 0);
        wicint = L'(8'h04);
        cyc("lv_disarmed", C_WIC, 0, '0, '0, 1, 0, 0);
        wicint = '0;

        // Masked-out line pends but never wakes; pend is sticky
        wicload = 1'b1; wicmask = L'(8'h01);
        cyc("mo_load", C_WIC, 0, '0, L'(8'h01), 1, 0, 0);
        wicload = 1'b0; wicmask = '0; wicint = L'(8'h80);
        cyc("mo_pend", C_WIC, 0, L'(8'h80), L'(8'h01), 1, 0, 0);
        wicint = '0;
        cyc("mo_sticky", C_WIC, 0, L'(8'h80), L'(8'h01), 1, 0, 0);
        cyc("mo_nowake", C_WIC, 0, L'(8'h80), L'(8'h01), 1, 0, 0);
        wicclear = 1'b1;
        cyc("mo_clear", C_WIC, 0, '0, '0, 1, 0, 0);
        wicclear = 1'b0;

        // Request in the load cycle is pended; request in the clear cycle lost
        wicload = 1'b1; wicmask = L'(8'h02); wicint = L'(8'h02);
        cyc("sl_load", C_WIC, 0, L'(8'h02), L'(8'h02), 1, 0, 0);
        wicload = 1'b0; wicmask = '0; wicint = '0;
        cyc("sl_wake", C_WIC, 1, L'(8'h02), L'(8'h02), 1, 0, 0);
        wicclear = 1'b1; wicint = L'(8'h02);
        cyc("sc_lost", C_WIC, 1, '0, '0, 1, 0, 0);
        wicclear = 1'b0; wicint = '0;
        cyc("sc_fall", C_WIC, 0, '0, '0, 1, 0, 0);

        // LOAD and CLEAR together: clear wins and the WIC stays disarmed
        wicload = 1'b1; wicmask = L'(8'h0F);
        cyc("pr_arm", C_WIC, 0, '0, L'(8'h0F), 1, 0, 0);
        wicload = 1'b1; wicclear = 1'b1; wicmask = L'(8'hFF); wicint = L'(8'hFF);
        cyc("pr_both", C_WIC, 0, '0, '0, 1, 0, 0);
        wicload = 1'b0; wicclear = 1'b0; wicmask = '0;
        cyc("pr_disarmed", C_WIC, 0, '0, '0, 1, 0, 0);
        wicint = '0;
        cyc("pr_quiet", C_WIC, 0, '0, '0, 1, 0, 0);

`ifdef CORTEXM0_WIC_EDGE_EN
        // Edge line 40 held high from before arming never pends
        wicint = '0; wicint[40] = 1'b1;
        cyc("ed_high", C_WIC, 0, '0, '0, 1, 0, 0);
        wicload = 1'b1; wicmask = '0; wicmask[40] = 1'b1; wicedge = '0; wicedge[40] = 1'b1;
        cyc("ed_load", C_WIC, 0, '0, wicmask, 1, 0, 0);
        wicload = 1'b0;
        cyc("ed_held", C_WIC, 0, '0, wicmask, 1, 0, 0);
        wicint[40] = 1'b0;
        cyc("ed_low", C_WIC, 0, '0, wicmask, 1, 0, 0);
        wicint[40] = 1'b1;
        cyc("ed_rise", C_WIC, 0, wicmask, wicmask, 1, 0, 0);
        cyc("ed_wake", C_WIC, 1, wicmask, wicmask, 1, 0, 0);
        // Level line 63 in the same build pends while held
        wicint[63] = 1'b1;
        cyc("ed_level63", C_P, 0, {1'b1, 22'd0, 1'b1, 40'd0}, '0, 1, 0, 0);
        wicint = '0; wicclear = 1'b1;
        cyc("ed_clear", C_P | C_S, 0, '0, '0, 1, 0, 0);
        wicclear = 1'b0; wicmask = '0; wicedge = '0;
        cyc("ed_quiet", C_WIC, 0, '0, '0, 1, 0, 0);
`endif

        stim_done = 1'b1;
    end

endmodule : tb_cortexm0_wic_gen
